// File: rtl/field_pkg.sv
// Shared types and sizes for the velocity-field BRAM arbiter.
package field_pkg;

  localparam int unsigned FIELD_WIDTH  = 8;
  localparam int unsigned FIELD_HEIGHT = 6;
  localparam int unsigned FIELD_SIZE   = FIELD_WIDTH * FIELD_HEIGHT;
  localparam int unsigned FIELD_DATAW  = 96;
  localparam int unsigned FIELD_ADDRW  = $clog2(FIELD_SIZE);

  typedef struct packed {
    logic [31:0] xn;
    logic [31:0] yn;
    logic [31:0] mag;
  } field_word_t;

  typedef enum logic {
    NORMAL,
    FORCE
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DRAW,
    OWN_SOLV
  } owner_t;

  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/field_arbiter_if.sv
// Requester-side bus of the field arbiter: draw read port plus solver read/write ports.
interface field_arbiter_if #(
  parameter int unsigned ADDRW = field_pkg::FIELD_ADDRW,
  parameter int unsigned DATAW = field_pkg::FIELD_DATAW
);
  logic             draw_req;
  logic [ADDRW-1:0] draw_addr;
  logic             draw_gnt;
  logic             draw_rvalid;
  logic             solv_rd_req;
  logic [ADDRW-1:0] solv_rd_addr;
  logic             solv_rd_gnt;
  logic             solv_rvalid;
  logic [DATAW-1:0] rdata;
  logic             solv_wr_en;
  logic [ADDRW-1:0] solv_wr_addr;
  logic [DATAW-1:0] solv_wr_data;

  modport master (
    output draw_req, draw_addr, solv_rd_req, solv_rd_addr,
    output solv_wr_en, solv_wr_addr, solv_wr_data,
    input  draw_gnt, draw_rvalid, solv_rd_gnt, solv_rvalid, rdata
  );

  modport slave (
    input  draw_req, draw_addr, solv_rd_req, solv_rd_addr,
    input  solv_wr_en, solv_wr_addr, solv_wr_data,
    output draw_gnt, draw_rvalid, solv_rd_gnt, solv_rvalid, rdata
  );
endinterface

// File: rtl/field_rd_bypass.sv
// Read-data path: same-address write bypass, out-of-range zeroing and rdata hold.
module field_rd_bypass #(
  parameter int unsigned DATAW = 96,
  parameter int unsigned ADDRW = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_fire,
  input  logic [ADDRW-1:0] rd_addr,
  input  logic             rd_oor,
  input  logic             wr_we,
  input  logic [ADDRW-1:0] wr_addr,
  input  logic [DATAW-1:0] wr_data,
  input  logic             rd_valid,
  input  logic [DATAW-1:0] bram_data_out,
  output logic [DATAW-1:0] rdata
);

  logic             byp_q, byp_d;
  logic             oor_q, oor_d;
  logic [DATAW-1:0] byp_data_q, byp_data_d;
  logic [DATAW-1:0] hold_q, hold_d;
  logic [DATAW-1:0] fresh_c;

  // The BRAM returns stale data on a same-cycle collision, so the write word is replayed.
  always_comb begin
    byp_d      = rd_fire && wr_we && (rd_addr == wr_addr);
    byp_data_d = byp_d ? wr_data : byp_data_q;
    oor_d      = rd_fire && rd_oor;
    if (oor_q) begin
      fresh_c = '0;
    end else if (byp_q) begin
      fresh_c = byp_data_q;
    end else begin
      fresh_c = bram_data_out;
    end
    rdata  = rd_valid ? fresh_c : hold_q;
    hold_d = rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_q      <= 1'b0;
      oor_q      <= 1'b0;
      byp_data_q <= '0;
      hold_q     <= '0;
    end else begin
      byp_q      <= byp_d;
      oor_q      <= oor_d;
      byp_data_q <= byp_data_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: rtl/field_arbiter.sv
// Shares the velocity-field BRAM read/write ports between the draw block and the solver.
module field_arbiter
  import field_pkg::*;
#(
  parameter int unsigned DATAW        = 96,
  parameter int unsigned DEPTH        = 48,
  parameter int unsigned ADDRW        = $clog2(DEPTH),
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  field_arbiter_if.slave   bus,
  output logic [ADDRW-1:0] bram_addr_read,
  input  logic [DATAW-1:0] bram_data_out,
  output logic             bram_we,
  output logic [ADDRW-1:0] bram_addr_write,
  output logic [DATAW-1:0] bram_data_in,
  output logic             addr_err
);

  localparam int unsigned CNTW = 4;

  arb_state_t       state_q, state_d;
  logic [CNTW-1:0]  starve_cnt_q, starve_cnt_d;
  owner_t           owner_q, owner_d;
  logic [ADDRW-1:0] rd_addr_q, rd_addr_d;
  logic             addr_err_q, addr_err_d;

  logic             draw_gnt_c, solv_gnt_c, rd_fire_c;
  logic [ADDRW-1:0] rd_addr_c;
  logic             rd_oor_c, wr_oor_c, bram_we_c;

  // Grant FSM: draw has priority until the solver has been denied STARVE_LIMIT times.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    draw_gnt_c   = 1'b0;
    solv_gnt_c   = 1'b0;
    case (state_q)
      NORMAL: begin
        if (bus.draw_req) begin
          draw_gnt_c = 1'b1;
        end else if (bus.solv_rd_req) begin
          solv_gnt_c = 1'b1;
        end
        if (bus.solv_rd_req && !solv_gnt_c) begin
          starve_cnt_d = CNTW'(starve_cnt_q + 1'b1);
        end else begin
          starve_cnt_d = '0;
        end
        if (starve_cnt_d == CNTW'(STARVE_LIMIT)) begin
          state_d = FORCE;
        end
      end
      FORCE: begin
        if (bus.solv_rd_req) begin
          solv_gnt_c = 1'b1;
        end else if (bus.draw_req) begin
          draw_gnt_c = 1'b1;
        end
        state_d      = NORMAL;
        starve_cnt_d = '0;
      end
      default: begin
        state_d      = NORMAL;
        starve_cnt_d = '0;
      end
    endcase
  end

  // Read address steering, owner tag and address checks.
  always_comb begin
    rd_fire_c  = draw_gnt_c | solv_gnt_c;
    rd_addr_c  = draw_gnt_c ? bus.draw_addr : bus.solv_rd_addr;
    rd_oor_c   = !addr_in_range(32'(rd_addr_c), DEPTH);
    wr_oor_c   = !addr_in_range(32'(bus.solv_wr_addr), DEPTH);
    bram_we_c  = bus.solv_wr_en && !wr_oor_c;
    rd_addr_d  = rd_fire_c ? rd_addr_c : rd_addr_q;
    if (draw_gnt_c) begin
      owner_d = OWN_DRAW;
    end else if (solv_gnt_c) begin
      owner_d = OWN_SOLV;
    end else begin
      owner_d = OWN_NONE;
    end
    addr_err_d = addr_err_q || (rd_fire_c && rd_oor_c) || (bus.solv_wr_en && wr_oor_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= NORMAL;
      starve_cnt_q <= '0;
      owner_q      <= OWN_NONE;
      rd_addr_q    <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      rd_addr_q    <= rd_addr_d;
      addr_err_q   <= addr_err_d;
    end
  end

  field_rd_bypass #(
    .DATAW (DATAW),
    .ADDRW (ADDRW)
  ) u_rd_bypass (
    .clk           (clk),
    .rst           (rst),
    .rd_fire       (rd_fire_c),
    .rd_addr       (rd_addr_c),
    .rd_oor        (rd_oor_c),
    .wr_we         (bram_we_c),
    .wr_addr       (bus.solv_wr_addr),
    .wr_data       (bus.solv_wr_data),
    .rd_valid      (owner_q != OWN_NONE),
    .bram_data_out (bram_data_out),
    .rdata         (bus.rdata)
  );

  assign bus.draw_gnt    = draw_gnt_c;
  assign bus.solv_rd_gnt = solv_gnt_c;
  assign bus.draw_rvalid = (owner_q == OWN_DRAW);
  assign bus.solv_rvalid = (owner_q == OWN_SOLV);

  // The BRAM registers the address itself, so the read address goes out unregistered.
  assign bram_addr_read  = rd_addr_d;
  assign bram_we         = bram_we_c;
  assign bram_addr_write = bus.solv_wr_addr;
  assign bram_data_in    = bus.solv_wr_data;
  assign addr_err        = addr_err_q;

endmodule

// File: tb/tb_field_arbiter.sv
// Directed bench for field_arbiter with a behavioural 1-cycle-read BRAM.
module tb_field_arbiter;
  import field_pkg::*;

  localparam int unsigned DEPTH = 48;
  localparam int unsigned DATAW = 96;
  localparam int unsigned ADDRW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  field_arbiter_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus ();

  logic [ADDRW-1:0] bram_addr_read, bram_addr_write;
  logic [DATAW-1:0] bram_data_out, bram_data_in;
  logic             bram_we, addr_err;

  field_arbiter #(
    .DATAW(DATAW), .DEPTH(DEPTH), .ADDRW(ADDRW), .STARVE_LIMIT(4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .bram_addr_read  (bram_addr_read),
    .bram_data_out   (bram_data_out),
    .bram_we         (bram_we),
    .bram_addr_write (bram_addr_write),
    .bram_data_in    (bram_data_in),
    .addr_err        (addr_err)
  );

  function automatic logic [DATAW-1:0] init_word(input int i);
    field_word_t w;
    w.xn  = 32'(i);
    w.yn  = 32'(3 * i + 1);
    w.mag = 32'hC0DE_0000 | 32'(i);
    return w;
  endfunction

  // BRAM model: registered read returning old data on collision; garbage beyond DEPTH.
  logic [DATAW-1:0] mem [DEPTH];
  logic             loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= init_word(i);
      loaded <= 1'b1;
      bram_data_out <= '0;
    end else begin
      if (bram_we && (int'(bram_addr_write) < int'(DEPTH))) mem[bram_addr_write] <= bram_data_in;
      bram_data_out <= (int'(bram_addr_read) < int'(DEPTH)) ? mem[bram_addr_read] : '1;
    end
  end

  logic [DATAW-1:0] exp_mem [DEPTH];
  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [DATAW-1:0] obs, input logic [DATAW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive just after the rising edge, return at the falling edge for sampling.
  task automatic cyc(input logic dr, input int da, input logic sr, input int sa,
                     input logic we, input int wa, input logic [DATAW-1:0] wd, input logic r);
    @(posedge clk);
    #1;
    rst              = r;
    bus.draw_req     = dr;
    bus.draw_addr    = ADDRW'(da);
    bus.solv_rd_req  = sr;
    bus.solv_rd_addr = ADDRW'(sa);
    bus.solv_wr_en   = we;
    bus.solv_wr_addr = ADDRW'(wa);
    bus.solv_wr_data = wd;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 0, '0, 1'b0);
  endtask

  localparam logic [DATAW-1:0] WD_A5 = {12{8'hA5}};
  localparam logic [DATAW-1:0] WD_9  = 96'h0000_0009_1111_2222_3333_4444;
  localparam logic [DATAW-1:0] WD_3  = 96'h0303_0303_5555_6666_7777_8888;

  initial begin
    logic prev_s;
    for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = init_word(i);
    rst = 1'b1;
    bus.draw_req = 1'b0; bus.draw_addr = '0;
    bus.solv_rd_req = 1'b0; bus.solv_rd_addr = '0;
    bus.solv_wr_en = 1'b0; bus.solv_wr_addr = '0; bus.solv_wr_data = '0;

    // Reset state
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 0, '0, 1'b1);
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 0, '0, 1'b1);
    chk("rst_draw_gnt", bus.draw_gnt, 0);
    chk("rst_solv_gnt", bus.solv_rd_gnt, 0);
    chk("rst_draw_rvalid", bus.draw_rvalid, 0);
    chk("rst_solv_rvalid", bus.solv_rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_bram_we", bram_we, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst_addr_read", bram_addr_read, 0);
    idle();

    // Draw-only read of address 5
    cyc(1'b1, 5, 1'b0, 0, 1'b0, 0, '0, 1'b0);
    chk("a_draw_gnt", bus.draw_gnt, 1);
    chk("a_solv_gnt", bus.solv_rd_gnt, 0);
    chk("a_addr_read", bram_addr_read, 5);
    idle();
    chk("a_draw_rvalid", bus.draw_rvalid, 1);
    chk("a_solv_rvalid", bus.solv_rvalid, 0);
    chk("a_rdata", bus.rdata, exp_mem[5]);
    idle();
    chk("a_rvalid_drop", bus.draw_rvalid, 0);
    chk("a_rdata_hold", bus.rdata, exp_mem[5]);
    chk("a_addr_hold", bram_addr_read, 5);

    // Continuous contention: solver forced every fifth cycle
    prev_s = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc(1'b1, 1, 1'b1, 2, 1'b0, 0, '0, 1'b0);
      chk("b_draw_gnt", bus.draw_gnt, (c % 5 != 4));
      chk("b_solv_gnt", bus.solv_rd_gnt, (c % 5 == 4));
      if (c > 0) begin
        chk("b_solv_rvalid", bus.solv_rvalid, prev_s);
        chk("b_rdata", bus.rdata, prev_s ? exp_mem[2] : exp_mem[1]);
      end
      prev_s = (c % 5 == 4);
    end
    idle();
    chk("b_last_solv_rvalid", bus.solv_rvalid, 1);
    chk("b_last_rdata", bus.rdata, exp_mem[2]);

    // Solver drops exactly when FORCE is entered: draw takes the slot, counter restarts
    for (int c = 0; c < 10; c++) begin
      cyc(1'b1, 1, (c != 4), 2, 1'b0, 0, '0, 1'b0);
      chk("b2_draw_gnt", bus.draw_gnt, (c != 9));
      chk("b2_solv_gnt", bus.solv_rd_gnt, (c == 9));
    end
    idle();

    // Same-address read-during-write takes the write data
    cyc(1'b1, 7, 1'b0, 0, 1'b1, 7, WD_A5, 1'b0);
    exp_mem[7] = WD_A5;
    chk("c_draw_gnt", bus.draw_gnt, 1);
    chk("c_bram_we", bram_we, 1);
    chk("c_addr_write", bram_addr_write, 7);
    chk("c_data_in", bram_data_in, WD_A5);
    idle();
    chk("c_bypass_rvalid", bus.draw_rvalid, 1);
    chk("c_bypass_rdata", bus.rdata, WD_A5);
    cyc(1'b1, 7, 1'b0, 0, 1'b0, 0, '0, 1'b0);
    idle();
    chk("c_reread_rdata", bus.rdata, WD_A5);
    cyc(1'b1, 8, 1'b0, 0, 1'b1, 9, WD_9, 1'b0);
    exp_mem[9] = WD_9;
    idle();
    chk("c_nocollide_rdata", bus.rdata, exp_mem[8]);

    // Out-of-range read and write
    cyc(1'b0, 0, 1'b1, 48, 1'b1, 50, 96'h1234, 1'b0);
    chk("d_solv_gnt", bus.solv_rd_gnt, 1);
    chk("d_bram_we", bram_we, 0);
    idle();
    chk("d_solv_rvalid", bus.solv_rvalid, 1);
    chk("d_rdata_zero", bus.rdata, 0);
    chk("d_addr_err", addr_err, 1);
    cyc(1'b0, 0, 1'b0, 0, 1'b1, 3, WD_3, 1'b0);
    exp_mem[3] = WD_3;
    chk("d_inrange_we", bram_we, 1);
    chk("d_addr_err_sticky", addr_err, 1);
    idle();
    idle();
    chk("d_addr_err_sticky2", addr_err, 1);

    // Reset while a solver read is being granted
    cyc(1'b0, 0, 1'b1, 4, 1'b0, 0, '0, 1'b1);
    chk("e_solv_gnt_in_rst", bus.solv_rd_gnt, 1);
    idle();
    chk("e_solv_rvalid", bus.solv_rvalid, 0);
    chk("e_draw_rvalid", bus.draw_rvalid, 0);
    chk("e_rdata", bus.rdata, 0);
    chk("e_addr_err", addr_err, 0);
    chk("e_addr_read", bram_addr_read, 0);

    // Reset with the starvation counter at 3 of 4 must restart the count
    for (int c = 0; c < 3; c++) cyc(1'b1, 1, 1'b1, 2, 1'b0, 0, '0, 1'b0);
    cyc(1'b1, 1, 1'b1, 2, 1'b0, 0, '0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      cyc(1'b1, 1, 1'b1, 2, 1'b0, 0, '0, 1'b0);
      if (c == 0) chk("e2_draw_rvalid", bus.draw_rvalid, 0);
      chk("e2_solv_gnt", bus.solv_rd_gnt, (c == 4));
    end
    idle();

    // Back-to-back draw sweep of the whole field
    for (int i = 0; i < int'(DEPTH); i++) begin
      cyc(1'b1, i, 1'b0, 0, 1'b0, 0, '0, 1'b0);
      chk("f_draw_gnt", bus.draw_gnt, 1);
      chk("f_solv_rvalid", bus.solv_rvalid, 0);
      if (i > 0) begin
        chk("f_draw_rvalid", bus.draw_rvalid, 1);
        chk("f_rdata", bus.rdata, exp_mem[i-1]);
      end
    end
    idle();
    chk("f_last_rvalid", bus.draw_rvalid, 1);
    chk("f_last_rdata", bus.rdata, exp_mem[DEPTH-1]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
